// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants for the VGA timing source and the colour stage.
// Also holds the counter type and a window-compare helper used by both.
package vga_timing_pkg;

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic HS_POL = 1'b0;
    localparam logic VS_POL = 1'b0;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    // True when lo <= c < lo+len.
    function automatic logic in_window(input cnt_t c, input int lo, input int len);
        return (int'(c) >= lo) && (int'(c) < lo + len);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing source on clk_50M: pixel strobe, coordinates, syncs, display
// enable and line/frame start pulses, all updated together on the edge that opens a strobe.
module vga_timing_gen #(
    parameter int   H_VIS  = vga_timing_pkg::H_VIS,
    parameter int   H_FP   = vga_timing_pkg::H_FP,
    parameter int   H_SYNC = vga_timing_pkg::H_SYNC,
    parameter int   H_BP   = vga_timing_pkg::H_BP,
    parameter int   V_VIS  = vga_timing_pkg::V_VIS,
    parameter int   V_FP   = vga_timing_pkg::V_FP,
    parameter int   V_SYNC = vga_timing_pkg::V_SYNC,
    parameter int   V_BP   = vga_timing_pkg::V_BP,
    parameter logic HS_POL = vga_timing_pkg::HS_POL,
    parameter logic VS_POL = vga_timing_pkg::VS_POL,
    parameter logic DIV2   = 1'b1
) (
    input  logic                             clk_50M,
    input  logic                             rst,
    output logic                             pix_en,
    output logic [vga_timing_pkg::CNT_W-1:0] h_cnt,
    output logic [vga_timing_pkg::CNT_W-1:0] v_cnt,
    output logic                             de,
    output logic                             hsync,
    output logic                             vsync,
    output logic                             line_start,
    output logic                             frame_start
);
    import vga_timing_pkg::*;

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    logic toggle_q,  toggle_d;
    logic started_q, started_d;
    cnt_t h_q,       h_d;
    cnt_t v_q,       v_d;
    logic de_q,      de_d;
    logic hs_q,      hs_d;
    logic vs_q,      vs_d;
    logic line_q,    line_d;
    logic frame_q,   frame_d;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through this block infers a latch.
        toggle_d  = DIV2 ? ~toggle_q : 1'b1;
        started_d = started_q;
        h_d       = h_q;
        v_d       = v_q;
        de_d      = de_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        line_d    = line_q;
        frame_d   = frame_q;

        // Advance on the edge that raises pix_en, so the strobe cycle already shows the new pixel.
        if (toggle_d) begin
            started_d = 1'b1;
            if (!started_q) begin
                h_d = '0;
                v_d = '0;
            end else if (h_q == cnt_t'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == cnt_t'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end

            de_d    = (int'(h_d) < H_VIS) && (int'(v_d) < V_VIS);
            hs_d    = in_window(h_d, H_VIS + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
            vs_d    = in_window(v_d, V_VIS + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
            line_d  = (h_d == '0);
            frame_d = (h_d == '0) && (v_d == '0);
        end
    end

    always_ff @(posedge clk_50M) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            toggle_q  <= 1'b0;
            started_q <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            de_q      <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            toggle_q  <= toggle_d;
            started_q <= started_d;
            h_q       <= h_d;
            v_q       <= v_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            line_q    <= line_d;
            frame_q   <= frame_d;
        end
    end

    assign pix_en      = toggle_q;
    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign de          = de_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign line_start  = toggle_q & line_q;
    assign frame_start = toggle_q & frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (full 640x480, shrunken raster,
// positive syncs without divider) checked cycle by cycle plus line/frame period statistics.
module tb_vga_timing_gen;

    typedef struct {
        int hv, hf, h_sync, hb;
        int vv, vf, v_sync, vb;
        bit hp, vp, div2;
    } tcfg_t;

    logic clk_50M = 1'b0;
    logic rst     = 1'b1;
    always #10 clk_50M = ~clk_50M;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tcfg_t       cfg      [3];
    bit          per_line [3] = '{1'b1, 1'b0, 1'b1};
    int          n_edges  [3] = '{0, 0, 0};
    logic [25:0] last_exp [3];
    logic [25:0] exp_q    [3][$];
    logic [25:0] obs      [3];

    bit seen     [3] = '{0, 0, 0};
    int last_cyc [3] = '{0, 0, 0};
    int sync_cnt [3] = '{0, 0, 0};
    int de_cnt   [3] = '{0, 0, 0};

    logic       pe0, de0, hs0, vs0, ls0, fs0;
    logic [9:0] h0, v0;
    logic       pe1, de1, hs1, vs1, ls1, fs1;
    logic [9:0] h1, v1;
    logic       pe2, de2, hs2, vs2, ls2, fs2;
    logic [9:0] h2, v2;

    vga_timing_gen u_full (
        .clk_50M(clk_50M), .rst(rst), .pix_en(pe0), .h_cnt(h0), .v_cnt(v0),
        .de(de0), .hsync(hs0), .vsync(vs0), .line_start(ls0), .frame_start(fs0)
    );

    vga_timing_gen #(
        .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_small (
        .clk_50M(clk_50M), .rst(rst), .pix_en(pe1), .h_cnt(h1), .v_cnt(v1),
        .de(de1), .hsync(hs1), .vsync(vs1), .line_start(ls1), .frame_start(fs1)
    );

    vga_timing_gen #(
        .HS_POL(1'b1), .VS_POL(1'b1), .DIV2(1'b0)
    ) u_pos (
        .clk_50M(clk_50M), .rst(rst), .pix_en(pe2), .h_cnt(h2), .v_cnt(v2),
        .de(de2), .hsync(hs2), .vsync(vs2), .line_start(ls2), .frame_start(fs2)
    );

    assign obs[0] = {pe0, h0, v0, de0, hs0, vs0, ls0, fs0};
    assign obs[1] = {pe1, h1, v1, de1, hs1, vs1, ls1, fs1};
    assign obs[2] = {pe2, h2, v2, de2, hs2, vs2, ls2, fs2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", tag, cyc, got, want);
        end
    endtask

    // Expected outputs after n clock edges with rst low, derived from the strobe count.
    function automatic logic [25:0] model(input tcfg_t c, input int n);
        int   ht, vt, k, p, h, v;
        logic pe, de, hs, vs, ls, fs;
        ht = c.hv + c.hf + c.h_sync + c.hb;
        vt = c.vv + c.vf + c.v_sync + c.vb;
        if (n == 0) return {1'b0, 10'd0, 10'd0, 1'b0, ~c.hp, ~c.vp, 2'b00};
        pe = c.div2 ? (n % 2 == 1) : 1'b1;
        k  = c.div2 ? (n + 1) / 2 : n;
        p  = k - 1;
        h  = p % ht;
        v  = (p / ht) % vt;
        de = (h < c.hv) && (v < c.vv);
        hs = (h >= c.hv + c.hf && h < c.hv + c.hf + c.h_sync) ? c.hp : ~c.hp;
        vs = (v >= c.vv + c.vf && v < c.vv + c.vf + c.v_sync) ? c.vp : ~c.vp;
        ls = pe && (h == 0);
        fs = ls && (v == 0);
        return {pe, 10'(h), 10'(v), de, hs, vs, ls, fs};
    endfunction

    task automatic stat_step(input int i);
        tcfg_t       c;
        logic [25:0] o;
        int          ht, vt;
        logic        pulse;
        c  = cfg[i];
        o  = obs[i];
        ht = c.hv + c.hf + c.h_sync + c.hb;
        vt = c.vv + c.vf + c.v_sync + c.vb;
        if (rst) begin
            seen[i] = 1'b0;
        end else if (o[25] === 1'b1) begin
            pulse = per_line[i] ? o[1] : o[0];
            if (pulse === 1'b1) begin
                if (seen[i]) begin
                    check($sformatf("period%0d", i), cyc - last_cyc[i],
                          (c.div2 ? 2 : 1) * ht * (per_line[i] ? 1 : vt));
                    check($sformatf("sync_strobes%0d", i), sync_cnt[i],
                          per_line[i] ? c.h_sync : c.v_sync * ht);
                    if (!per_line[i])
                        check($sformatf("de_strobes%0d", i), de_cnt[i], c.hv * c.vv);
                end
                seen[i]     = 1'b1;
                last_cyc[i] = cyc;
                sync_cnt[i] = 0;
                de_cnt[i]   = 0;
            end
            if (per_line[i] ? (o[3] === c.hp) : (o[2] === c.vp)) sync_cnt[i]++;
            if (o[4] === 1'b1) de_cnt[i]++;
        end
    endtask

    always @(posedge clk_50M) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) n_edges[i] = 0;
            else     n_edges[i]++;
            last_exp[i] = model(cfg[i], n_edges[i]);
            exp_q[i].push_back(last_exp[i]);
        end
    end

    always @(negedge clk_50M) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (exp_q[i].size() == 0) begin
                check($sformatf("sb_empty%0d", i), 32'd0, 32'd1);
            end else begin
                check($sformatf("sb%0d", i), 32'(obs[i]), 32'(exp_q[i].pop_front()));
                stat_step(i);
            end
        end
    end

    initial begin
        bit hit;
        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1'b1};
        cfg[1] = '{16, 2, 3, 4, 10, 2, 2, 3, 1'b0, 1'b0, 1'b1};
        cfg[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        repeat (5) @(negedge clk_50M);
        rst = 1'b0;
        repeat (6000) @(negedge clk_50M);

        // Mid-frame reset on the small raster at (20,8), timed so the next edge would be a strobe.
        hit = 1'b0;
        for (int t = 0; t < 2000 && !hit; t++) begin
            @(negedge clk_50M);
            hit = (last_exp[1][24:15] == 10'd20) && (last_exp[1][14:5] == 10'd8) &&
                  (last_exp[1][25] == 1'b0);
        end
        check("mid_rst_reach", 32'(hit), 32'd1);
        rst = 1'b1;
        repeat (3) @(negedge clk_50M);
        rst = 1'b0;
        repeat (4000) @(negedge clk_50M);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
